reg_univ: RTL and testbench

//   Parametrised universal register; successor to the fixed 8-bit load/hold register.

---
 rtl/reg_univ.sv | 96 +++++++++
 tb/tb_reg_univ.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/reg_univ.sv
// Universal WIDTH-bit register: load, shift, rotate and, with REG_UNIV_COUNT_EN, up/down count.
// Results appear one cycle after the enabled edge. Co is a registered flag; Zero is decoded from reg_out.
module reg_univ #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Res,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] reg_in,
  input  logic             Sin_lsb,
  input  logic             Sin_msb,
  output logic [WIDTH-1:0] reg_out,
  output logic             Co,
  output logic             Zero
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
`ifdef REG_UNIV_COUNT_EN
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
`endif

  logic [WIDTH-1:0] reg_q, reg_d;
  logic             co_q, co_d;

  always_comb begin
    reg_d = reg_q;
    co_d  = co_q;
    if (En) begin
      case (Mode)
        MODE_HOLD: begin
          reg_d = reg_q;
          co_d  = co_q;
        end
        MODE_LOAD: begin
          reg_d = reg_in;
          co_d  = 1'b0;
        end
        MODE_SHL: begin
          reg_d = {reg_q[WIDTH-2:0], Sin_lsb};
          co_d  = reg_q[WIDTH-1];
        end
        MODE_SHR: begin
          reg_d = {Sin_msb, reg_q[WIDTH-1:1]};
          co_d  = reg_q[0];
        end
        MODE_ROL: begin
          reg_d = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
          co_d  = reg_q[WIDTH-1];
        end
        MODE_ROR: begin
          reg_d = {reg_q[0], reg_q[WIDTH-1:1]};
          co_d  = reg_q[0];
        end
`ifdef REG_UNIV_COUNT_EN
        // Carry/borrow is the wrap condition, taken from the operand rather than an extra adder bit.
        MODE_INC: begin
          reg_d = reg_q + ONE;
          co_d  = &reg_q;
        end
        MODE_DEC: begin
          reg_d = reg_q - ONE;
          co_d  = ~|reg_q;
        end
`endif
        default: begin
          reg_d = reg_q;
          co_d  = co_q;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Res) begin
      reg_q <= RESET_VAL;
      co_q  <= 1'b0;
    end else begin
      reg_q <= reg_d;
      co_q  <= co_d;
    end
  end

  assign reg_out = reg_q;
  assign Co      = co_q;
  assign Zero    = ~|reg_q;

endmodule

// File: tb/tb_reg_univ.sv
// Randomised bench for reg_univ: two instances (RESET_VAL 0 and 8'h3C) against an arithmetic model.
module tb_reg_univ;

  logic       Clk;
  logic       Res;
  logic       En;
  logic [2:0] Mode;
  logic [7:0] reg_in;
  logic       Sin_lsb;
  logic       Sin_msb;
  logic [7:0] out0, out1;
  logic       co0, co1, z0, z1;

  int n_checks = 0;
  int n_errors = 0;
  int m  [2];
  int mc [2];
  int rv [2] = '{0, 60};

  reg_univ #(.WIDTH(8), .RESET_VAL(8'h00)) dut0 (
    .Clk(Clk), .Res(Res), .En(En), .Mode(Mode), .reg_in(reg_in),
    .Sin_lsb(Sin_lsb), .Sin_msb(Sin_msb), .reg_out(out0), .Co(co0), .Zero(z0)
  );

  reg_univ #(.WIDTH(8), .RESET_VAL(8'h3C)) dut1 (
    .Clk(Clk), .Res(Res), .En(En), .Mode(Mode), .reg_in(reg_in),
    .Sin_lsb(Sin_lsb), .Sin_msb(Sin_msb), .reg_out(out1), .Co(co1), .Zero(z1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour expressed as integer arithmetic on 0..255.
  task automatic model_step(input int res, input int en, input int mode,
                            input int din, input int sl, input int sm);
    for (int i = 0; i < 2; i++) begin
      if (res != 0) begin
        m[i]  = rv[i];
        mc[i] = 0;
      end else if (en != 0) begin
        case (mode)
          1: begin m[i] = din; mc[i] = 0; end
          2: begin mc[i] = m[i] / 128; m[i] = (m[i] * 2) % 256 + sl; end
          3: begin mc[i] = m[i] % 2;   m[i] = m[i] / 2 + sm * 128; end
          4: begin mc[i] = m[i] / 128; m[i] = (m[i] * 2) % 256 + mc[i]; end
          5: begin mc[i] = m[i] % 2;   m[i] = m[i] / 2 + mc[i] * 128; end
`ifdef REG_UNIV_COUNT_EN
          6: begin mc[i] = (m[i] == 255) ? 1 : 0; m[i] = (m[i] + 1) % 256; end
          7: begin mc[i] = (m[i] == 0) ? 1 : 0;   m[i] = (m[i] + 255) % 256; end
`endif
          default: ;
        endcase
      end
    end
  endtask

  task automatic step(input int res, input int en, input int mode,
                      input int din, input int sl, input int sm);
    Res     = (res != 0);
    En      = (en != 0);
    Mode    = 3'(mode);
    reg_in  = 8'(din);
    Sin_lsb = (sl != 0);
    Sin_msb = (sm != 0);
    @(posedge Clk);
    model_step(res, en, mode, din, sl, sm);
    #1;
    check("reg_out0", 32'(out0), 32'(m[0]));
    check("co0",      32'(co0),  32'(mc[0]));
    check("zero0",    32'(z0),   (m[0] == 0) ? 32'd1 : 32'd0);
    check("reg_out1", 32'(out1), 32'(m[1]));
    check("co1",      32'(co1),  32'(mc[1]));
    check("zero1",    32'(z1),   (m[1] == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [7:0] rol_co;
    rol_co = 8'b1000_0001;
    m  = '{0, 0};
    mc = '{0, 0};
    Res = 1'b1; En = 1'b0; Mode = 3'd0; reg_in = 8'h00; Sin_lsb = 1'b0; Sin_msb = 1'b0;

    // Reset state, then reset after a load.
    step(1, 0, 0, 0, 0, 0);
    check("rst_out0", 32'(out0), 32'h00);
    check("rst_out1", 32'(out1), 32'h3C);
    step(0, 1, 1, 8'hA5, 0, 0);
    check("load_a5", 32'(out0), 32'hA5);
    step(1, 0, 0, 0, 0, 0);
    check("rst_after_load0", 32'(out0), 32'h00);
    check("rst_zero0", 32'(z0), 32'd1);
    check("rst_after_load1", 32'(out1), 32'h3C);
    check("rst_zero1", 32'(z1), 32'd0);

    // Shift left then right with serial inputs.
    step(0, 1, 1, 8'h81, 0, 0);
    step(0, 1, 2, 0, 1, 0);
    check("shl_out", 32'(out0), 32'h03);
    check("shl_co",  32'(co0),  32'd1);
    step(0, 1, 3, 0, 1, 0);
    check("shr_out", 32'(out0), 32'h01);
    check("shr_co",  32'(co0),  32'd1);

    // Full rotation returns the original word.
    step(0, 1, 1, 8'h81, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 4, 0, 1, 1);
      check("rol_co", 32'(co0), 32'(rol_co[7-k]));
    end
    check("rol_wrap", 32'(out0), 32'h81);

    // Enable low holds regardless of mode; HOLD mode holds.
    step(0, 1, 1, 8'h55, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 2, 8'hFF, 1, 1);
    check("en0_hold", 32'(out0), 32'h55);
    step(0, 1, 0, 8'hFF, 1, 1);
    check("mode0_hold", 32'(out0), 32'h55);
    check("mode0_co",   32'(co0),  32'd0);

    // Count wrap-around.
    step(0, 1, 1, 8'hFE, 0, 0);
    step(0, 1, 6, 0, 0, 0);
`ifdef REG_UNIV_COUNT_EN
    check("inc1", 32'(out0), 32'hFF);
    check("inc1_co", 32'(co0), 32'd0);
`else
    check("inc1_hold", 32'(out0), 32'hFE);
`endif
    step(0, 1, 6, 0, 0, 0);
`ifdef REG_UNIV_COUNT_EN
    check("inc2", 32'(out0), 32'h00);
    check("inc2_co", 32'(co0), 32'd1);
    check("inc2_zero", 32'(z0), 32'd1);
`else
    check("inc2_hold", 32'(out0), 32'hFE);
`endif
    step(0, 1, 7, 0, 0, 0);
`ifdef REG_UNIV_COUNT_EN
    check("dec", 32'(out0), 32'hFF);
    check("dec_co", 32'(co0), 32'd1);
`else
    check("dec_hold", 32'(out0), 32'hFE);
    check("dec_hold_co", 32'(co0), 32'd0);
`endif

    // Reset beats a simultaneous load.
    step(0, 1, 2, 0, 1, 0);
    step(1, 1, 1, 8'hFF, 0, 0);
    check("rst_wins0", 32'(out0), 32'h00);
    check("rst_wins_co", 32'(co0), 32'd0);
    check("rst_wins1", 32'(out1), 32'h3C);

    // Random operation mix with occasional resets.
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 31) == 0) ? 1 : 0,
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 255)),
           int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
